// File: rtl/rr_arbiter4_pkg.sv
// Shared constants and state type for the four-way round-robin arbiter.
package rr_arbiter4_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter4_if
  import rr_arbiter4_pkg::*;
;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant_idx, grant_valid, timeout
  );

endinterface

// File: rtl/rr_arbiter4_pick.sv
// Combinational round-robin pick: first set req bit scanning upward from last_ptr+1.
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    winner  = '0;
    found   = 1'b0;
    idx     = '0;
    any_req = |req;
    // Offsets 1..4 wrap naturally in IDX_W bits, leaving the previous owner last.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = last_ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with done/hold-timeout release and registered outputs.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input logic         clk,
  input logic         rst_n,
  rr_arbiter4_if.slave bus
);

  localparam bit              HOLD_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(HOLD_EN ? MAX_HOLD - 1 : 0);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             valid_q, valid_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             limit_hit;

  rr_pick4 u_pick (
    .req      (bus.req),
    .last_ptr (last_q),
    .winner   (winner),
    .any_req  (any_req)
  );

  assign limit_hit = HOLD_EN && (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '1;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (any_req) begin
          idx_d   = winner;
          last_d  = winner;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (bus.done || limit_hit) begin
          // done takes credit when it coincides with the limit.
          to_d = !bus.done;
          if (any_req) begin
            idx_d  = winner;
            last_d = winner;
            cnt_d  = '0;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = to_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with a cycle model compared on every falling edge.
module tb_rr_arbiter4;

  localparam int MAXH = 4;

  logic clk;
  logic rst_n;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks;
  int failures;

  // Model: owner index, how many cycles the owner has held (1 in the first cycle).
  int m_idx;
  int m_last;
  int m_age;
  bit m_valid;
  bit m_to;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_last  <= 3;
      m_age   <= 0;
      m_to    <= 1'b0;
    end else if (!m_valid) begin
      m_to <= 1'b0;
      if (bus.req != 4'b0000) begin
        m_valid <= 1'b1;
        m_idx   <= pick(bus.req, m_last);
        m_last  <= pick(bus.req, m_last);
        m_age   <= 1;
      end
    end else if (bus.done || (MAXH != 0 && m_age == MAXH)) begin
      m_to <= !bus.done;
      if (bus.req != 4'b0000) begin
        m_idx  <= pick(bus.req, m_last);
        m_last <= pick(bus.req, m_last);
        m_age  <= 1;
      end else begin
        m_valid <= 1'b0;
      end
    end else begin
      m_age <= m_age + 1;
      m_to  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("model_grant_valid", int'(bus.grant_valid), int'(m_valid));
      chk("model_grant_idx", int'(bus.grant_idx), m_idx);
      chk("model_timeout", int'(bus.timeout), int'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string nm, input int idx, input int valid, input int to);
    chk({nm, "_idx"}, int'(bus.grant_idx), idx);
    chk({nm, "_valid"}, int'(bus.grant_valid), valid);
    chk({nm, "_timeout"}, int'(bus.timeout), to);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    lit("reset", 0, 0, 0);
    rst_n = 1'b1;
  endtask

  logic [3:0] oh;
  logic [3:0] exp_oh [4];

  initial begin
    checks   = 0;
    failures = 0;
    exp_oh   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    #12;
    lit("reset_initial", 0, 0, 0);
    rst_n = 1'b1;

    // 1: full rotation, done every third cycle, decoder one-hot follows.
    tick();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      bus.done = 1'b0;
      lit("rot", g % 4, 1, 0);
      oh = 4'b0001 << bus.grant_idx;
      chk("rot_onehot", int'(oh), int'(exp_oh[g % 4]));
      tick();
      tick();
      bus.done = 1'b1;
    end
    tick();
    bus.done = 1'b0;
    lit("rot_end", 1, 1, 0);
    bus.req  = 4'b0000;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    lit("rot_idle", 1, 0, 0);

    // 2: single request, then release to IDLE keeps grant_idx.
    pulse_reset();
    bus.req = 4'b0100;
    tick();
    lit("single", 2, 1, 0);
    bus.req  = 4'b0000;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    lit("single_rel", 2, 0, 0);
    tick();
    lit("single_idle", 2, 0, 0);

    // 3: hold timeout alternates between two requesters.
    pulse_reset();
    bus.req = 4'b0011;
    tick();
    for (int k = 0; k < 4; k++) begin
      lit("hold0", 0, 1, 0);
      tick();
    end
    lit("to_1", 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      lit("hold1", 1, 1, 0);
    end
    tick();
    lit("to_0", 0, 1, 1);
    tick();
    lit("after_to", 0, 1, 0);
    bus.req  = 4'b0000;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;

    // 4: owner drops req; grant persists until the timeout releases to IDLE.
    pulse_reset();
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      lit("drop_hold", 2, 1, 0);
    end
    tick();
    lit("drop_to", 2, 0, 1);
    tick();
    lit("drop_idle", 2, 0, 0);

    // 5: done coincides with the hold limit.
    pulse_reset();
    bus.req = 4'b1000;
    tick();
    tick();
    tick();
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    lit("coincide", 3, 1, 0);

    // 6: asynchronous reset mid-grant, rotation restarts at 0.
    #1;
    rst_n = 1'b0;
    #1;
    lit("async_rst", 0, 0, 0);
    bus.req = 4'b1010;
    rst_n   = 1'b1;
    tick();
    lit("post_rst", 1, 1, 0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    lit("post_rst_next", 3, 1, 0);
    bus.req = 4'b0000;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter with registered outputs.
- Sits directly upstream of the team's 2-to-4 decoder: grant_idx drives the decoder's 2-bit data_in, and the decoder's 4-bit out becomes the one-hot select for the granted requester.
- Holds a grant until the owner signals done or a programmable hold timeout expires, then rotates priority.

Parameters:
- MAX_HOLD, 16: maximum cycles a grant may be held before forced release. 0 disables the timeout.
- CNT_W, 8: width of the hold counter. MAX_HOLD must be < 2**CNT_W.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst_n  input  1  asynchronous reset, active-low.
- req  input  4  request vector; bit i = requester i.
- done  input  1  current owner releases the grant (sampled only in GRANT).
- grant_idx  output  2  encoded index of the current owner; feeds the decoder's data_in.
- grant_valid  output  1  grant_idx is a live grant.
- timeout  output  1  one-cycle pulse when a grant is force-released by the hold counter.

Behaviour:
- All outputs are registered. Reset is asynchronous, active-low, and takes effect immediately, including mid-grant.
- Reset values:
  - state = IDLE
  - grant_idx = 2'b00
  - grant_valid = 0
  - timeout = 0
  - last_ptr = 2'b11 (so requester 0 has top priority after reset)
  - hold_cnt = 0
- Winner selection:
  - Scan indices last_ptr+1, +2, +3, +4, all mod 4; the first with req set wins.
  - The previous owner is therefore lowest priority.
- IDLE:
  - req == 0: stay in IDLE, grant_valid = 0, grant_idx holds its last value.
  - req != 0: at the next edge, grant_idx = winner, grant_valid = 1, last_ptr = winner, hold_cnt = 0, go to GRANT.
  - Latency from req to grant_valid is 1 cycle.
  - done is ignored in IDLE.
- GRANT:
  - hold_cnt increments by 1 each cycle. It saturates and never wraps.
  - Release condition: done = 1, or (MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1).
  - On release with req != 0 (the owner's own bit included, at lowest priority): the new winner is granted at the same edge. grant_valid stays 1, grant_idx changes, last_ptr updates, hold_cnt = 0, state stays GRANT. There are no dead cycles.
  - On release with req == 0: grant_valid = 0, go to IDLE.
  - The owner dropping its req bit while granted does NOT release the grant; only done or the timeout does.
- timeout:
  - Asserted for exactly the one cycle following a release caused by the counter while done = 0.
  - If done and the counter limit coincide, the release is attributed to done and timeout stays 0.
- Single requester: re-granted back-to-back to itself indefinitely (same grant_idx, hold_cnt restarts).
- Reset mid-grant: outputs return to reset values immediately, and rotation restarts from requester 0.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE = 1'b0, GRANT = 1'b1
  - requester count constant N_REQ = 4
  - index width constant IDX_W = 2
- One natural combinational sub-module, rr_pick4: inputs req[3:0] and last_ptr[1:0]; outputs winner[1:0] and any_req.
- The top level holds the FSM, hold counter and output registers.

Test Plan:
1. Reset then req = 4'b1111 with done pulsed every 3rd cycle -> grant_idx sequence 0,1,2,3,0; grant_valid = 1 throughout with no gaps; the decoder downstream shows 0001,0010,0100,1000.
2. After reset, req = 4'b0100 -> one cycle later grant_idx = 2, grant_valid = 1. Then req = 0 and done = 1 -> next cycle grant_valid = 0, grant_idx stays 2.
3. MAX_HOLD = 4, req = 4'b0011, done never asserted -> owner 0 held 4 cycles, then grant_idx = 1 with a timeout pulse of 1 cycle. Owner 1 is held 4 cycles, then grant returns to 0.
4. Granted owner 2 drops req while other bits are 0 and done = 0 -> grant_valid stays 1 and grant_idx stays 2 until done or timeout.
5. done and the timeout limit in the same cycle with req = 4'b1000 -> grant_idx = 3 next cycle, timeout = 0.
6. rst_n driven low mid-grant (grant_idx = 3) asynchronously, between clock edges -> grant_valid = 0 and grant_idx = 0 immediately. After release with req = 4'b1010, first grant goes to 1.
